// File: rtl/cybernid_pkg.sv
// Shared types and helpers for the CyberNID input packer.
//   packer_state_t : packer FSM states
//   ACT_W          : width of one activation code
//   quantise()     : maps a signed word onto a 2-bit code using three thresholds
package cybernid_pkg;

  localparam int unsigned ACT_W = 2;
  // Quantiser working width; callers sign-extend feature words and thresholds to it.
  localparam int unsigned Q_W   = 32;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } packer_state_t;

  // Full-width signed compare against three ascending thresholds.
  function automatic logic [ACT_W-1:0] quantise(
    input logic signed [Q_W-1:0] x,
    input logic signed [Q_W-1:0] t1,
    input logic signed [Q_W-1:0] t2,
    input logic signed [Q_W-1:0] t3
  );
    if (x < t1)      return 2'b00;
    else if (x < t2) return 2'b01;
    else if (x < t3) return 2'b10;
    else             return 2'b11;
  endfunction

endpackage

// File: rtl/cybernid_feature_quantizer.sv
// Combinational comparator trio turning one signed feature word into an activation code.
//   x      : signed feature word
//   code_c : 2-bit activation code (combinational)
module cybernid_feature_quantizer
  import cybernid_pkg::*;
#(
  parameter int unsigned             IN_W = 16,
  parameter logic signed [IN_W-1:0]  T1   = -16'sd256,
  parameter logic signed [IN_W-1:0]  T2   = 16'sd0,
  parameter logic signed [IN_W-1:0]  T3   = 16'sd256
) (
  input  logic signed [IN_W-1:0] x,
  output logic [ACT_W-1:0]       code_c
);

  // Size casts of signed operands sign-extend, so the compare stays signed.
  assign code_c = quantise(Q_W'(x), Q_W'(T1), Q_W'(T2), Q_W'(T3));

endmodule

// File: rtl/cybernid_input_packer.sv
// Collects one flow sample of NUM_FEATURES signed words, quantises each word and
// packs the codes into M0, then holds M0 under valid/ready until taken.
//   clk, rst          : clock, asynchronous active-high reset
//   s_valid/s_ready   : feature beat handshake, s_data word, s_last end of sample
//   m_valid/m_ready   : packed vector handshake, M0 vector (feature k at [2k+1:2k])
//   frame_err         : one-cycle pulse when a malformed sample is discarded
//   frame_cnt         : delivered-vector count, wraps
module cybernid_input_packer
  import cybernid_pkg::*;
#(
  parameter int unsigned             NUM_FEATURES = 64,
  parameter int unsigned             IN_W         = 16,
  parameter logic signed [IN_W-1:0]  T1           = -16'sd256,
  parameter logic signed [IN_W-1:0]  T2           = 16'sd0,
  parameter logic signed [IN_W-1:0]  T3           = 16'sd256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic signed [IN_W-1:0]        s_data,
  input  logic                          s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [ACT_W*NUM_FEATURES-1:0] M0,
  output logic                          frame_err,
  output logic [15:0]                   frame_cnt
);

  localparam int unsigned IDX_W = (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEATURES - 1);

  // Thresholds must be strictly ascending for the code bands to make sense.
  if (!((T1 < T2) && (T2 < T3))) begin : g_bad_thresholds
    $error("cybernid_input_packer: thresholds must satisfy T1 < T2 < T3");
  end

  packer_state_t    state;
  logic [IDX_W-1:0] idx;
  logic [ACT_W-1:0] code_c;

  cybernid_feature_quantizer #(
    .IN_W (IN_W),
    .T1   (T1),
    .T2   (T2),
    .T3   (T3)
  ) u_quant (
    .x      (s_data),
    .code_c (code_c)
  );

  // Packer FSM, slot writes and frame counter; all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FILL;
      idx       <= '0;
      s_ready   <= 1'b1;
      m_valid   <= 1'b0;
      M0        <= '0;
      frame_err <= 1'b0;
      frame_cnt <= '0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        FILL: begin
          if (s_valid) begin
            // Slot write is harmless on discarded samples; M0 is only meaningful with m_valid.
            M0[{idx, 1'b0} +: ACT_W] <= code_c;
            if (idx == IDX_LAST) begin
              idx <= '0;
              if (s_last) begin
                state   <= HOLD;
                s_ready <= 1'b0;
                m_valid <= 1'b1;
              end else begin
                // Over-long sample: flag once, then swallow beats up to its s_last.
                frame_err <= 1'b1;
                state     <= DRAIN;
              end
            end else if (s_last) begin
              frame_err <= 1'b1;
              idx       <= '0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        DRAIN: begin
          if (s_valid && s_last) begin
            state <= FILL;
          end
        end
        HOLD: begin
          if (m_ready) begin
            state     <= FILL;
            s_ready   <= 1'b1;
            m_valid   <= 1'b0;
            idx       <= '0;
            frame_cnt <= frame_cnt + 16'd1;
          end
        end
        default: begin
          state   <= FILL;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
          idx     <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cybernid_input_packer.sv
// Directed self-checking bench for cybernid_input_packer with default parameters.
module tb_cybernid_input_packer;

  logic               clk = 1'b0;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic signed [15:0] s_data;
  logic               s_last;
  logic               m_valid;
  logic               m_ready;
  logic [127:0]       M0;
  logic               frame_err;
  logic [15:0]        frame_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  logic prev_mv = 1'b0;
  int rises[$];

  cybernid_input_packer dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .M0        (M0),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  // Cycle counter and m_valid rising-edge log, sampled mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (m_valid && !prev_mv) rises.push_back(cyc);
    prev_mv <= m_valid;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Kind 0: quantiser boundary words; kind 1: ramp -512 + 16k.
  function automatic logic signed [15:0] word_of(input int kind, input int k);
    logic signed [15:0] tab [8];
    tab = '{-16'sd257, -16'sd256, -16'sd1, 16'sd0, 16'sd255, 16'sd256, -16'sd32768, 16'sd32767};
    if (kind == 0) return tab[k % 8];
    return 16'(k * 16 - 512);
  endfunction

  function automatic logic [127:0] exp_vec(input int kind);
    logic [1:0]   ctab [8];
    logic [127:0] v;
    ctab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b11, 2'b00, 2'b11};
    v = '0;
    for (int k = 0; k < 64; k++) begin
      if (kind == 0) v[2*k +: 2] = ctab[k % 8];
      else           v[2*k +: 2] = 2'(k / 16);
    end
    return v;
  endfunction

  // Present one beat and wait until it is accepted; returns #1 after the accepting edge.
  task automatic send_beat(input logic signed [15:0] d, input logic last);
    logic acc;
    int   n;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    n = 0;
    acc = 1'b0;
    while (n < 50) begin
      acc = s_ready;
      @(posedge clk); #1;
      n++;
      if (acc) break;
    end
    if (!acc) check("beat_accept_timeout", 128'(acc), 128'(1));
  endtask

  task automatic send_beats(input int kind, input int k0, input int k1, input int last_at);
    for (int k = k0; k < k1; k++) send_beat(word_of(kind, k), 1'(k == last_at));
  endtask

  task automatic idle_inputs();
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    idle_inputs();
    m_ready = 1'b1;
    rst     = 1'b1;
    #1;
    // Reset values
    check("rst_s_ready",   128'(s_ready),   128'(1));
    check("rst_m_valid",   128'(m_valid),   128'(0));
    check("rst_M0",        M0,              128'(0));
    check("rst_frame_err", 128'(frame_err), 128'(0));
    check("rst_frame_cnt", 128'(frame_cnt), 128'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Quantiser boundaries, latency and transfer with m_ready high
    m_ready = 1'b1;
    send_beats(0, 0, 63, -1);
    check("t1_mvalid_before_last", 128'(m_valid), 128'(0));
    send_beats(0, 63, 64, 63);
    check("t1_mvalid", 128'(m_valid), 128'(1));
    check("t1_sready", 128'(s_ready), 128'(0));
    check("t1_M0",     M0,            exp_vec(0));
    idle_inputs();
    @(posedge clk); #1;
    check("t1_frame_cnt",    128'(frame_cnt), 128'(1));
    check("t1_mvalid_after", 128'(m_valid),   128'(0));
    check("t1_sready_after", 128'(s_ready),   128'(1));

    // Backpressure
    do_reset();
    m_ready = 1'b0;
    send_beats(1, 0, 64, 63);
    idle_inputs();
    for (int c = 0; c < 10; c++) begin
      check("bp_mvalid", 128'(m_valid), 128'(1));
      check("bp_sready", 128'(s_ready), 128'(0));
      check("bp_M0",     M0,            exp_vec(1));
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_mvalid_after", 128'(m_valid),   128'(0));
    check("bp_sready_after", 128'(s_ready),   128'(1));
    check("bp_frame_cnt",    128'(frame_cnt), 128'(1));

    // Early s_last on beat 10
    do_reset();
    send_beats(1, 0, 10, 9);
    check("early_err_pulse", 128'(frame_err), 128'(1));
    check("early_no_mvalid", 128'(m_valid),   128'(0));
    idle_inputs();
    @(posedge clk); #1;
    check("early_err_clear", 128'(frame_err), 128'(0));
    send_beats(0, 0, 64, 63);
    check("early_next_M0",     M0,            exp_vec(0));
    check("early_next_mvalid", 128'(m_valid), 128'(1));
    idle_inputs();
    @(posedge clk); #1;
    check("early_frame_cnt", 128'(frame_cnt), 128'(1));

    // Missing s_last: 64 beats, then 5 drained beats ending with s_last
    do_reset();
    send_beats(1, 0, 64, -1);
    check("miss_err_pulse", 128'(frame_err), 128'(1));
    check("miss_no_mvalid", 128'(m_valid),   128'(0));
    for (int j = 0; j < 5; j++) begin
      send_beat(16'sd100, 1'(j == 4));
      check("drain_err_low",   128'(frame_err), 128'(0));
      check("drain_no_mvalid", 128'(m_valid),   128'(0));
      check("drain_sready",    128'(s_ready),   128'(1));
    end
    idle_inputs();
    @(posedge clk); #1;
    send_beats(1, 0, 64, 63);
    check("miss_next_M0",     M0,            exp_vec(1));
    check("miss_next_mvalid", 128'(m_valid), 128'(1));
    idle_inputs();
    @(posedge clk); #1;
    check("miss_frame_cnt", 128'(frame_cnt), 128'(1));

    // Reset mid-sample after one delivered vector
    do_reset();
    send_beats(1, 0, 64, 63);
    idle_inputs();
    @(posedge clk); #1;
    check("rm_pre_cnt", 128'(frame_cnt), 128'(1));
    send_beats(0, 0, 30, -1);
    #3;
    rst = 1'b1;
    #1;
    check("rm_M0",        M0,              128'(0));
    check("rm_mvalid",    128'(m_valid),   128'(0));
    check("rm_sready",    128'(s_ready),   128'(1));
    check("rm_frame_err", 128'(frame_err), 128'(0));
    check("rm_frame_cnt", 128'(frame_cnt), 128'(0));
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    send_beats(0, 0, 64, 63);
    check("rm_fresh_M0", M0, exp_vec(0));
    idle_inputs();
    @(posedge clk); #1;
    check("rm_fresh_cnt", 128'(frame_cnt), 128'(1));

    // Back-to-back with s_valid held high
    do_reset();
    m_ready = 1'b1;
    rises.delete();
    send_beats(0, 0, 64, 63);
    send_beats(1, 0, 64, 63);
    send_beats(0, 0, 64, 63);
    idle_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("b2b_vectors", 128'(rises.size()), 128'(3));
    if (rises.size() == 3) begin
      check("b2b_gap1", 128'(rises[1] - rises[0]), 128'(65));
      check("b2b_gap2", 128'(rises[2] - rises[1]), 128'(65));
    end
    check("b2b_frame_cnt", 128'(frame_cnt), 128'(3));

    // frame_cnt wrap
    do_reset();
    force dut.frame_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_cnt;
    @(posedge clk); #1;
    check("wrap_pre", 128'(frame_cnt), 128'(16'hFFFF));
    send_beats(1, 0, 64, 63);
    idle_inputs();
    @(posedge clk); #1;
    check("wrap_cnt", 128'(frame_cnt), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
